// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Packs instruction field bundles into 32-bit R / I / JI / JII words and
// streams them into instruction memory at consecutive addresses from 0.
// Writes appear one cycle after the bundle is accepted. The load stops once
// LAST_ADDR has been written. A sticky flag records any I-format immediate
// that does not fit in 17 bits signed.

module instr_encoder_loader #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LAST_ADDR  = 4095
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            fmt,
    input  logic [4:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            shamt,
    input  logic [4:0]            aluop,
    input  logic [31:0]           imm,
    input  logic [26:0]           target,
    output logic                  imem_wren,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  err_imm_ovf
);

    // Load FSM encoding
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    // Instruction formats
    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_JI  = 2'b10;
    localparam logic [1:0] FMT_JII = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(LAST_ADDR);

    logic [0:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,     count_d;
    logic                  wren_q,      wren_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [31:0]           data_q,      data_d;
    logic                  err_q,       err_d;

    logic                  accept;
    logic [31:0]           enc_word;
    logic                  imm_ovf;

    // Handshake: only the LOAD state accepts, and clear blocks acceptance
    always_comb begin
        in_ready = (state_q == ST_LOAD) && !clear;
        accept   = in_valid && in_ready;
    end

    // Field packing per format; fields not used by the format are ignored
    always_comb begin
        enc_word = '0;
        imm_ovf  = 1'b0;
        case (fmt)
            FMT_R:   enc_word = {opcode, rd, rs, rt, shamt, aluop, 2'b00};
            FMT_I: begin
                enc_word = {opcode, rd, rs, imm[16:0]};
                // Fits 17-bit signed only if bits 31..17 all copy bit 16
                imm_ovf  = (imm[31:17] != {15{imm[16]}});
            end
            FMT_JI:  enc_word = {opcode, target};
            FMT_JII: enc_word = {opcode, rd, 22'b0};
            default: enc_word = '0;
        endcase
    end

    // Next-state: clear beats accept; the write port holds addr/data when idle
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wren_d   = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        err_d    = err_q;

        if (clear) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            count_d  = '0;
            err_d    = 1'b0;
        end else if (accept) begin
            wren_d  = 1'b1;
            addr_d  = wr_ptr_q;
            data_d  = enc_word;
            count_d = count_q + 1'b1;
            if (imm_ovf) begin
                err_d = 1'b1;
            end
            // The last address ends the load; the pointer is left there
            if (wr_ptr_q == LAST_PTR) begin
                state_d = ST_FULL;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // Output mapping
    always_comb begin
        imem_wren   = wren_q;
        imem_addr   = addr_q;
        imem_data   = data_q;
        count       = count_q;
        full        = (state_q == ST_FULL);
        err_imm_ovf = err_q;
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a small reference model and
// an expected-write scoreboard. Uses a 4-word memory (LAST_ADDR=3).

module tb_instr_encoder_loader;

    localparam int unsigned AW   = 4;
    localparam int          LAST = 3;

    logic          clock = 1'b0;
    logic          reset, clear, in_valid, in_ready;
    logic [1:0]    fmt;
    logic [4:0]    opcode, rd, rs, rt, shamt, aluop;
    logic [31:0]   imm;
    logic [26:0]   target;
    logic          imem_wren;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic [AW:0]   count;
    logic          full, err_imm_ovf;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    int          m_ptr, m_cnt;
    logic        m_full, m_err, m_wren;
    logic [31:0] m_addr, m_data;

    always #5 clock = ~clock;

    instr_encoder_loader #(
        .ADDR_WIDTH(AW),
        .LAST_ADDR (LAST)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .shamt      (shamt),
        .aluop      (aluop),
        .imm        (imm),
        .target     (target),
        .imem_wren  (imem_wren),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .count      (count),
        .full       (full),
        .err_imm_ovf(err_imm_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_enc();
        logic [31:0] w;
        case (fmt)
            2'b00:   w = {opcode, rd, rs, rt, shamt, aluop, 2'b00};
            2'b01:   w = {opcode, rd, rs, imm[16:0]};
            2'b10:   w = {opcode, target};
            default: w = {opcode, rd, 22'b0};
        endcase
        return w;
    endfunction

    function automatic logic model_ovf();
        return (fmt == 2'b01) &&
               (($signed(imm) < -32'sd65536) || ($signed(imm) > 32'sd65535));
    endfunction

    // One clock cycle: check ready, advance model, then check registered outputs
    task automatic step();
        exp_t e;
        logic acc;
        #1;
        if (!reset) check("in_ready", 32'(in_ready), 32'(!m_full && !clear));
        acc = in_valid && !reset && !clear && !m_full;
        if (reset) begin
            m_ptr = 0; m_cnt = 0; m_full = 0; m_err = 0; m_wren = 0;
            m_addr = '0; m_data = '0;
            sb.delete();
        end else if (clear) begin
            m_ptr = 0; m_cnt = 0; m_full = 0; m_err = 0; m_wren = 0;
        end else if (acc) begin
            e.addr = AW'(m_ptr);
            e.data = model_enc();
            sb.push_back(e);
            m_wren = 1;
            m_cnt++;
            if (model_ovf()) m_err = 1;
            if (m_ptr == LAST) m_full = 1;
            else m_ptr++;
        end else begin
            m_wren = 0;
        end
        @(posedge clock);
        #1;
        check("imem_wren", 32'(imem_wren), 32'(m_wren));
        if (m_wren) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_mis++;
                $error("FAIL scoreboard: observed=empty expected=entry");
            end else begin
                e = sb.pop_front();
                m_addr = 32'(e.addr);
                m_data = e.data;
            end
        end
        check("imem_addr",   32'(imem_addr),   m_addr);
        check("imem_data",   imem_data,        m_data);
        check("count",       32'(count),       32'(m_cnt));
        check("full",        32'(full),        32'(m_full));
        check("err_imm_ovf", 32'(err_imm_ovf), 32'(m_err));
    endtask

    task automatic set_r(input logic [4:0] op, input logic [4:0] d, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] sh, input logic [4:0] al);
        fmt = 2'b00; opcode = op; rd = d; rs = s; rt = t; shamt = sh; aluop = al;
        imm = 32'hDEAD_BEEF; target = 27'h5A5A5A5;
    endtask

    task automatic set_i(input logic [4:0] op, input logic [4:0] d, input logic [4:0] s,
                         input logic [31:0] im);
        fmt = 2'b01; opcode = op; rd = d; rs = s; imm = im;
        rt = 5'h1F; shamt = 5'h15; aluop = 5'h0A; target = 27'h7FFFFFF;
    endtask

    task automatic set_ji(input logic [4:0] op, input logic [26:0] tg);
        fmt = 2'b10; opcode = op; target = tg;
        rd = 5'h1F; rs = 5'h1F; rt = 5'h1F; shamt = 5'h1F; aluop = 5'h1F; imm = 32'hFFFF_FFFF;
    endtask

    task automatic set_jii(input logic [4:0] op, input logic [4:0] d);
        fmt = 2'b11; opcode = op; rd = d;
        rs = 5'h1F; rt = 5'h1F; shamt = 5'h1F; aluop = 5'h1F; imm = 32'hFFFF_FFFF; target = 27'h7FFFFFF;
    endtask

    initial begin
        reset = 1; clear = 0; in_valid = 0;
        set_r(0, 0, 0, 0, 0, 0);
        m_ptr = 0; m_cnt = 0; m_full = 0; m_err = 0; m_wren = 0; m_addr = '0; m_data = '0;

        // Reset state
        step(); step();
        reset = 0;
        step();
        check("reset_ready", 32'(in_ready), 32'd1);

        // R word
        in_valid = 1; set_r(0, 3, 1, 2, 0, 0);
        step();
        check("t1_data", imem_data, 32'h00C2_2000);
        check("t1_addr", 32'(imem_addr), 32'd0);

        // I word with imm=-1, then JI
        set_i(5, 1, 0, 32'hFFFF_FFFF);
        step();
        check("t2_i_data", imem_data, 32'h2841_FFFF);
        check("t2_i_err", 32'(err_imm_ovf), 32'd0);
        set_ji(1, 27'h100);
        step();
        check("t2_ji_data", imem_data, 32'h0800_0100);

        // Idle cycle: addr/data hold
        in_valid = 0;
        step();
        clear = 1; step(); clear = 0;

        // Overflowing immediate: sticky until clear
        in_valid = 1; set_i(5, 1, 0, 32'h0001_0000);
        step();
        check("t3_data", imem_data, 32'h2841_0000);
        check("t3_err", 32'(err_imm_ovf), 32'd1);
        set_jii(7, 9);
        step();
        in_valid = 0;
        step();
        check("t3_err_sticky", 32'(err_imm_ovf), 32'd1);
        clear = 1; step(); clear = 0;
        check("t3_err_cleared", 32'(err_imm_ovf), 32'd0);

        // Immediate range boundaries
        in_valid = 1;
        set_i(2, 4, 6, 32'hFFFF_0000); step();
        set_i(3, 5, 7, 32'h0000_FFFF); step();
        check("imm_edges_no_err", 32'(err_imm_ovf), 32'd0);
        set_i(4, 8, 9, 32'hFFFE_FFFF); step();
        in_valid = 0;
        clear = 1; step(); clear = 0;

        // Fill to LAST_ADDR with valid held for 6 cycles
        in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_r(5'(i + 1), 5'(i + 2), 5'(i + 3), 5'(i + 4), 5'(i), 5'(3 * i));
            step();
        end
        check("t4_full", 32'(full), 32'd1);
        check("t4_ready", 32'(in_ready), 32'd0);
        check("t4_count", 32'(count), 32'd4);
        check("t4_last_addr", 32'(imem_addr), 32'd3);

        // Clear while full: back to LOAD once clear drops
        in_valid = 0;
        clear = 1; step(); clear = 0;
        step();
        check("clear_full_ready", 32'(in_ready), 32'd1);

        // Clear after two accepts with valid held
        in_valid = 1; set_r(1, 1, 1, 1, 1, 1);
        step();
        set_r(2, 2, 2, 2, 2, 2);
        step();
        clear = 1;
        #1;
        check("t5_inflight_wren", 32'(imem_wren), 32'd1);
        check("t5_inflight_addr", 32'(imem_addr), 32'd1);
        step();
        clear = 0;
        set_jii(3, 3);
        step();
        check("t5_addr", 32'(imem_addr), 32'd0);
        check("t5_count", 32'(count), 32'd1);

        // Reset in the cycle after an accept
        set_ji(4, 27'h123_4567);
        step();
        in_valid = 0; reset = 1;
        step();
        check("t6_wren", 32'(imem_wren), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        reset = 0;
        step();
        check("t6_ready", 32'(in_ready), 32'd1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
